fluxo_dados_rodadas: RTL and testbench

Parametrised datapath for the sequence-memory game, successor to the single-round data flow. Holds an address counter, a round-limit counter, a switch register, a fixed pattern ROM and a comparator. Adds address-versus-limit comparison, a "play made" edge detector on the switches and a saturating timeout counter. It is driven by the game control unit and exposes debug buses for the board displays.

---
 rtl/fluxo_dados_pkg.sv | 13 +
 rtl/fluxo_dados_rodadas_contador_m.sv | 27 ++
 rtl/fluxo_dados_rodadas.sv | 79 +++++++
 tb/tb_fluxo_dados_rodadas.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fluxo_dados_pkg.sv
// fluxo_dados_pkg: shared defaults and pattern ROM for the rounds datapath
package fluxo_dados_pkg;

    localparam int DATA_W_DEF      = 4;
    localparam int ADDR_W_DEF      = 4;
    localparam int TIMEOUT_CYC_DEF = 5000;

    // One-hot walking pattern: word[i] = 1 << (i mod dataW)
    function automatic logic [31:0] rom_word(input int addr, input int dataW);
        return 32'd1 << (addr % dataW);
    endfunction

endpackage

// File: rtl/fluxo_dados_rodadas_contador_m.sv
// contador_m: modulo-M counter with clear, enable and optional saturation at M-1
module contador_m #(
    parameter int M      = 16,
    parameter bit SATURA = 1'b0,
    localparam int W     = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    assign fim = (Q == W'(M - 1));

    // Clear beats count; at the top value either hold (saturating) or wrap to 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            Q <= '0;
        else if (zera)
            Q <= '0;
        else if (conta)
            Q <= fim ? (SATURA ? Q : '0) : Q + 1'b1;
    end

endmodule

// File: rtl/fluxo_dados_rodadas.sv
// fluxo_dados_rodadas: sequence-game datapath with counters, ROM, comparator, play detector and timeout
module fluxo_dados_rodadas
    import fluxo_dados_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              zeraE,
    input  logic              contaE,
    input  logic              zeraL,
    input  logic              contaL,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic              zeraT,
    input  logic              contaT,
    input  logic [DATA_W-1:0] chaves,
    output logic              chavesIgualMemoria,
    output logic              enderecoIgualLimite,
    output logic              enderecoMenorLimite,
    output logic              fimE,
    output logic              fimL,
    output logic              jogada_feita,
    output logic              timeout,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [ADDR_W-1:0] db_limite,
    output logic [DATA_W-1:0] db_chaves,
    output logic [DATA_W-1:0] db_memoria
);

    localparam int T_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic           ativoPrev;
    logic [T_W-1:0] unusedT;

    contador_m #(.M(1 << ADDR_W), .SATURA(1'b0)) contadorE (
        .clock(clock), .reset_n(reset_n), .zera(zeraE), .conta(contaE),
        .Q(db_contagem), .fim(fimE)
    );

    contador_m #(.M(1 << ADDR_W), .SATURA(1'b0)) contadorL (
        .clock(clock), .reset_n(reset_n), .zera(zeraL), .conta(contaL),
        .Q(db_limite), .fim(fimL)
    );

    contador_m #(.M(TIMEOUT_CYC), .SATURA(1'b1)) contadorT (
        .clock(clock), .reset_n(reset_n), .zera(zeraT), .conta(contaT),
        .Q(unusedT), .fim(timeout)
    );

    assign db_memoria          = DATA_W'(rom_word(int'(db_contagem), DATA_W));
    assign chavesIgualMemoria  = (db_chaves == db_memoria);
    assign enderecoIgualLimite = (db_contagem == db_limite);
    assign enderecoMenorLimite = (db_contagem < db_limite);

    // Switch register: clear wins over load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            db_chaves <= '0;
        else if (zeraR)
            db_chaves <= '0;
        else if (registraR)
            db_chaves <= chaves;
    end

    // Rising edge of any-switch-active gives a single registered pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ativoPrev    <= 1'b0;
            jogada_feita <= 1'b0;
        end else begin
            ativoPrev    <= |chaves;
            jogada_feita <= (|chaves) & ~ativoPrev;
        end
    end

endmodule

// File: tb/tb_fluxo_dados_rodadas.sv
// tb_fluxo_dados_rodadas: directed and random checks of the datapath against a behavioural model
module tb_fluxo_dados_rodadas;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int TC = 10;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic zeraE = 0, contaE = 0, zeraL = 0, contaL = 0;
    logic zeraR = 0, registraR = 0, zeraT = 0, contaT = 0;
    logic [DW-1:0] chaves = '0;
    logic chavesIgualMemoria, enderecoIgualLimite, enderecoMenorLimite;
    logic fimE, fimL, jogada_feita, timeout;
    logic [AW-1:0] db_contagem, db_limite;
    logic [DW-1:0] db_chaves, db_memoria;

    int checks = 0;
    int failures = 0;
    bit chk = 0;

    int mE = 0, mL = 0, mR = 0, mT = 0, mPrev = 0, mJf = 0;

    fluxo_dados_rodadas #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TC)) dut (
        .clock(clock), .reset_n(reset_n),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
        .chaves(chaves),
        .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite),
        .enderecoMenorLimite(enderecoMenorLimite),
        .fimE(fimE), .fimL(fimL), .jogada_feita(jogada_feita), .timeout(timeout),
        .db_contagem(db_contagem), .db_limite(db_limite),
        .db_chaves(db_chaves), .db_memoria(db_memoria)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expMem();
        return 1 << (mE % DW);
    endfunction

    // Behavioural model: what each register must hold after an edge
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mE <= 0; mL <= 0; mR <= 0; mT <= 0; mPrev <= 0; mJf <= 0;
        end else begin
            mE    <= zeraE ? 0 : contaE ? (mE + 1) % (1 << AW) : mE;
            mL    <= zeraL ? 0 : contaL ? (mL + 1) % (1 << AW) : mL;
            mR    <= zeraR ? 0 : registraR ? int'(chaves) : mR;
            mT    <= zeraT ? 0 : contaT ? ((mT < TC - 1) ? mT + 1 : mT) : mT;
            mJf   <= (chaves != 0 && mPrev == 0) ? 1 : 0;
            mPrev <= (chaves != 0) ? 1 : 0;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clock) begin
        if (chk) begin
            check("db_contagem", 32'(db_contagem), 32'(mE));
            check("db_limite", 32'(db_limite), 32'(mL));
            check("db_chaves", 32'(db_chaves), 32'(mR));
            check("db_memoria", 32'(db_memoria), 32'(expMem()));
            check("chavesIgualMemoria", 32'(chavesIgualMemoria), 32'(mR == expMem()));
            check("enderecoIgualLimite", 32'(enderecoIgualLimite), 32'(mE == mL));
            check("enderecoMenorLimite", 32'(enderecoMenorLimite), 32'(mE < mL));
            check("fimE", 32'(fimE), 32'(mE == (1 << AW) - 1));
            check("fimL", 32'(fimL), 32'(mL == (1 << AW) - 1));
            check("timeout", 32'(timeout), 32'(mT >= TC - 1));
            check("jogada_feita", 32'(jogada_feita), 32'(mJf));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle();
        zeraE = 0; contaE = 0; zeraL = 0; contaL = 0;
        zeraR = 0; registraR = 0; zeraT = 0; contaT = 0;
    endtask

    initial begin
        int pulses;
        int first;
        #2 reset_n = 1'b0;
        chk = 1;
        #1;
        check("rst_db_contagem", 32'(db_contagem), 0);
        check("rst_db_memoria", 32'(db_memoria), 1);
        check("rst_igualLimite", 32'(enderecoIgualLimite), 1);
        check("rst_menorLimite", 32'(enderecoMenorLimite), 0);
        check("rst_igualMemoria", 32'(chavesIgualMemoria), 0);
        check("rst_timeout", 32'(timeout), 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc();

        chaves = 4'b0001; registraR = 1;
        cyc();
        idle(); chaves = 0;
        check("load_igualMemoria", 32'(chavesIgualMemoria), 1);
        contaE = 1;
        cyc();
        idle();
        check("e1_contagem", 32'(db_contagem), 1);
        check("e1_memoria", 32'(db_memoria), 4'b0010);
        check("e1_igualMemoria", 32'(chavesIgualMemoria), 0);

        zeraE = 1; cyc(); idle();
        contaL = 1; cyc(3); idle();
        contaE = 1; cyc(2); idle();
        check("lim_menor", 32'(enderecoMenorLimite), 1);
        contaE = 1; cyc(); idle();
        check("lim_igual", 32'(enderecoIgualLimite), 1);
        check("lim_menor0", 32'(enderecoMenorLimite), 0);

        zeraE = 1; cyc(); idle();
        contaE = 1; cyc(15); idle();
        check("wrap_fimE", 32'(fimE), 1);
        check("wrap_15", 32'(db_contagem), 15);
        contaE = 1; cyc(); idle();
        check("wrap_0", 32'(db_contagem), 0);
        check("wrap_fimE0", 32'(fimE), 0);
        zeraE = 1; contaE = 1; cyc(); idle();
        check("zera_wins", 32'(db_contagem), 0);

        chaves = 0; cyc(2);
        chaves = 4'b0100; pulses = 0;
        repeat (6) begin cyc(); pulses += int'(jogada_feita); end
        check("pulse_one", 32'(pulses), 1);
        chaves = 4'b1000; pulses = 0;
        repeat (3) begin cyc(); pulses += int'(jogada_feita); end
        check("pulse_none", 32'(pulses), 0);
        chaves = 0; cyc(2);
        chaves = 4'b0001; pulses = 0;
        repeat (3) begin cyc(); pulses += int'(jogada_feita); end
        check("pulse_again", 32'(pulses), 1);
        chaves = 0;

        zeraT = 1; cyc(); idle();
        contaT = 1; first = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            if (timeout && first == 0) first = n;
        end
        check("timeout_edges", 32'(first), 9);
        check("timeout_hold", 32'(timeout), 1);
        zeraT = 1; cyc(); idle();
        check("timeout_clear", 32'(timeout), 0);

        zeraE = 1; cyc(); idle();
        contaE = 1; cyc(7);
        check("pre_rst_7", 32'(db_contagem), 7);
        #2 reset_n = 1'b0;
        #1;
        check("async_contagem", 32'(db_contagem), 0);
        check("async_limite", 32'(db_limite), 0);
        check("async_chaves", 32'(db_chaves), 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc(2);
        check("resume", 32'(db_contagem), 2);
        idle();

        for (int i = 0; i < 400; i++) begin
            zeraE = ($urandom_range(0, 19) == 0);
            contaE = $urandom_range(0, 1) == 1;
            zeraL = ($urandom_range(0, 19) == 0);
            contaL = $urandom_range(0, 2) == 0;
            zeraR = ($urandom_range(0, 9) == 0);
            registraR = $urandom_range(0, 1) == 1;
            zeraT = ($urandom_range(0, 24) == 0);
            contaT = $urandom_range(0, 3) != 0;
            chaves = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_n = 1'b0;
                #3 reset_n = 1'b1;
            end
            cyc();
        end

        chk = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
